// File: rtl/wb_arb2_pkg.sv
// Shared types for the two-master round-robin Wishbone arbiter.
package wb_arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef logic grant_t;

endpackage

// File: rtl/wb_arb2_rr_pick.sv
// Combinational round-robin picker for two requesters.
module wb_arb2_rr_pick
    import wb_arb2_pkg::*;
(
    input  logic [1:0] i_req,
    input  grant_t     i_last,
    output logic       o_valid,
    output grant_t     o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        unique case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_arb2_rr.sv
// Two-master round-robin arbiter onto one pipelined Wishbone slave.
// Optional slave watchdog enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2_rr
    import wb_arb2_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,
    output logic                    m0_stall_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,
    output logic                    m1_stall_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    input  logic                    s_stall_i
);

    state_t                    r_state;
    state_t                    w_state_nx;
    grant_t                    r_owner;
    grant_t                    r_last;
    logic [ADDR_WIDTH-1:0]     r_adr;
    logic [DATA_WIDTH/8-1:0]   r_sel;
    logic                      r_we;
    logic [DATA_WIDTH-1:0]     r_dat;

    logic [1:0] w_req;
    logic       w_valid;
    grant_t     w_grant;
    logic       w_accept;
    logic       w_busy;
    logic       w_resp;
    logic       w_owner_cyc;
    logic       w_to;
    logic       w_end;

    assign w_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    wb_arb2_rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    assign w_busy      = (r_state != IDLE);
    assign w_accept    = (r_state == IDLE) & w_valid;
    assign w_resp      = s_ack_i | s_err_i | s_rty_i;
    assign w_owner_cyc = r_owner ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB2_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A real slave response in the same cycle wins over the watchdog.
    assign w_to = w_busy & ~w_resp & (r_cnt == CW'(TIMEOUT_CYCLES));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_to = 1'b0;
`endif

    // Completion, watchdog expiry and owner abort all close the cycle.
    assign w_end = w_busy & (w_resp | w_to | ~w_owner_cyc);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: if (w_valid) w_state_nx = REQ;
            REQ: begin
                if (w_end)           w_state_nx = IDLE;
                else if (!s_stall_i) w_state_nx = WAIT;
            end
            WAIT: if (w_end) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_adr   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_owner <= w_grant;
                r_adr   <= w_grant ? m1_adr_i : m0_adr_i;
                r_sel   <= w_grant ? m1_sel_i : m0_sel_i;
                r_we    <= w_grant ? m1_we_i  : m0_we_i;
                r_dat   <= w_grant ? m1_dat_i : m0_dat_i;
            end
            if (w_end) r_last <= r_owner;
        end
    end

    assign s_cyc_o = w_busy;
    assign s_stb_o = (r_state == REQ);
    assign s_adr_o = r_adr;
    assign s_sel_o = r_sel;
    assign s_we_o  = r_we;
    assign s_dat_o = r_dat;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = s_ack_i & w_busy & ~r_owner;
    assign m1_ack_o = s_ack_i & w_busy &  r_owner;
    assign m0_err_o = (s_err_i | w_to) & w_busy & ~r_owner;
    assign m1_err_o = (s_err_i | w_to) & w_busy &  r_owner;
    assign m0_rty_o = s_rty_i & w_busy & ~r_owner;
    assign m1_rty_o = s_rty_i & w_busy &  r_owner;

    assign m0_stall_o = ~(w_accept & ~w_grant);
    assign m1_stall_o = ~(w_accept &  w_grant);

endmodule
